// File: rtl/data_unpack_pkg.sv
// Shared types and elaboration helpers for the parametrised word-to-value unpacker.
package data_unpack_pkg;

  // Fill counter container; wide enough for any accumulator up to 255 bits.
  localparam int FILL_MAX_W = 8;
  typedef logic [FILL_MAX_W-1:0] fill_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PKT,
    ST_TAIL
  } pkt_state_t;

  function automatic int clog2_fill(input int in_w, input int out_w);
    int n;
    int r;
    n = in_w + out_w;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic bit widths_ok(input int in_w, input int out_w);
    return (out_w >= 1) && (in_w >= out_w) && (clog2_fill(in_w, out_w) <= FILL_MAX_W);
  endfunction

endpackage

// File: rtl/data_unpack_merge.sv
// Accumulator update: optional right shift by one value, then OR-insert of a
// new word at the current fill offset. Bits at or above the offset are dropped.
module data_unpack_merge
  import data_unpack_pkg::*;
#(
  parameter int IN_W  = 32,
  parameter int OUT_W = 7,
  parameter int BUF_W = IN_W + OUT_W - 1
) (
  input  logic [BUF_W-1:0] acc_in,
  input  logic             shift,
  input  fill_t            offset,
  input  logic [IN_W-1:0]  data,
  input  logic             insert,
  output logic [BUF_W-1:0] acc_out
);

  logic [BUF_W-1:0] shifted;
  logic [BUF_W-1:0] keep_mask;
  logic [BUF_W-1:0] ins;

  // Masking above the offset also discards a dropped residual at packet end.
  always_comb begin
    shifted   = shift ? (acc_in >> OUT_W) : acc_in;
    keep_mask = ~({BUF_W{1'b1}} << offset);
    ins       = insert ? (BUF_W'(data) << offset) : '0;
    acc_out   = (shifted & keep_mask) | ins;
  end

endmodule

// File: rtl/data_unpack_param.sv
// data_unpack_param: repacks framed IN_W-bit words into a gap-free LSB-first
// stream of OUT_W-bit values, with valid/ready handshakes on both sides.
module data_unpack_param
  import data_unpack_pkg::*;
#(
  parameter int IN_W        = 32,
  parameter int OUT_W       = 7,
  parameter int PAD_PARTIAL = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             ready_out,
  input  logic             valid_in,
  input  logic [IN_W-1:0]  data_in,
  input  logic             sop_in,
  input  logic             eop_in,
  output logic             valid_out,
  input  logic             ready_in,
  output logic [OUT_W-1:0] data_out,
  output logic             sop_out,
  output logic             eop_out,
  output logic             err_out
);

  localparam int    BUF_W   = IN_W + OUT_W - 1;
  localparam bit    PAD     = (PAD_PARTIAL != 0);
  localparam fill_t OUT_WF  = fill_t'(OUT_W);
  localparam fill_t IN_WF   = fill_t'(IN_W);
  localparam fill_t EOP_THR = PAD ? fill_t'(1) : OUT_WF;

  if (!widths_ok(IN_W, OUT_W)) begin : g_bad_widths
    $error("data_unpack_param: need 1 <= OUT_W <= IN_W and a fill counter that fits");
  end

  logic [BUF_W-1:0] acc;
  logic [BUF_W-1:0] acc_next;
  fill_t            fill;
  fill_t            fill_rem;
  fill_t            fill_after;
  fill_t            fill_next;
  pkt_state_t       state;
  logic             first_pend;
  logic             err_q;
  logic             in_pkt;
  logic             eop_pend;
  logic             in_fire;
  logic             out_fire;
  logic             eop_fire;
  logic             new_pkt;
  logic             cont;
  logic             accept;
  logic             mid_sop;

  assign in_pkt   = (state == ST_PKT);
  assign eop_pend = (state == ST_TAIL);

  // fill_rem is what would remain if the current value fires; using it keeps
  // eop_out independent of ready_in so it holds under backpressure.
  assign fill_rem  = (fill >= OUT_WF) ? (fill - OUT_WF) : '0;
  assign valid_out = (fill >= OUT_WF) || (PAD && eop_pend && (fill != '0));
  assign sop_out   = valid_out && first_pend;
  assign eop_out   = valid_out && eop_pend && (fill_rem < EOP_THR);
  assign err_out   = err_q;

  assign out_fire   = valid_out && ready_in;
  assign eop_fire   = out_fire && eop_out;
  assign fill_after = eop_fire ? '0 : (out_fire ? fill_rem : fill);

  // Combinational path from ready_in: a value leaving this cycle makes room.
  assign ready_out = rst_n && (fill_after < OUT_WF) && !(eop_pend && (fill_after != '0));

  assign in_fire   = valid_in && ready_out;
  assign new_pkt   = in_fire && sop_in && !in_pkt;
  assign cont      = in_fire && in_pkt;
  assign accept    = new_pkt || cont;
  assign mid_sop   = cont && sop_in;
  assign fill_next = accept ? (fill_after + IN_WF) : fill_after;

  always_comb begin
    for (int i = 0; i < OUT_W; i++) begin
      data_out[i] = acc[i] && (fill > fill_t'(i));
    end
  end

  data_unpack_merge #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .BUF_W (BUF_W)
  ) u_merge (
    .acc_in  (acc),
    .shift   (out_fire),
    .offset  (fill_after),
    .data    (data_in),
    .insert  (accept),
    .acc_out (acc_next)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc        <= '0;
      fill       <= '0;
      state      <= ST_IDLE;
      first_pend <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      acc   <= acc_next;
      fill  <= fill_next;
      err_q <= mid_sop;
      if (out_fire) first_pend <= 1'b0;
      // A new packet may start in the same cycle the previous eop value leaves.
      if (new_pkt) begin
        first_pend <= 1'b1;
        state      <= eop_in ? ST_TAIL : ST_PKT;
      end else if (cont && eop_in) begin
        state <= ST_TAIL;
      end else if (eop_fire) begin
        state <= ST_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_data_unpack_param.sv
// Directed bench for data_unpack_param: one padded and one non-padded instance
// checked against hand-computed values and a small bit-concatenation model.
module tb_data_unpack_param;

  typedef struct {
    logic [31:0] d;
    bit          sop;
    bit          eop;
    bit          mid;
  } word_t;

  typedef struct {
    logic [6:0] d;
    bit         sop;
    bit         eop;
  } val_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, valid_in, sop_in, eop_in, ready_in, sel;
  logic [31:0] data_in;
  logic        ro1, vo1, so1, eo1, er1, ro0, vo0, so0, eo0, er0;
  logic [6:0]  d1, d0;
  logic        vi1, vi0, ro, vo, so, eo, er;
  logic [6:0]  dout;

  assign vi1  = valid_in && !sel;
  assign vi0  = valid_in && sel;
  assign ro   = sel ? ro0 : ro1;
  assign vo   = sel ? vo0 : vo1;
  assign so   = sel ? so0 : so1;
  assign eo   = sel ? eo0 : eo1;
  assign er   = sel ? er0 : er1;
  assign dout = sel ? d0 : d1;

  data_unpack_param #(.IN_W(32), .OUT_W(7), .PAD_PARTIAL(1)) dut (
    .clk(clk), .rst_n(rst_n), .ready_out(ro1), .valid_in(vi1), .data_in(data_in),
    .sop_in(sop_in), .eop_in(eop_in), .valid_out(vo1), .ready_in(ready_in),
    .data_out(d1), .sop_out(so1), .eop_out(eo1), .err_out(er1)
  );

  data_unpack_param #(.IN_W(32), .OUT_W(7), .PAD_PARTIAL(0)) dut_nopad (
    .clk(clk), .rst_n(rst_n), .ready_out(ro0), .valid_in(vi0), .data_in(data_in),
    .sop_in(sop_in), .eop_in(eop_in), .valid_out(vo0), .ready_in(ready_in),
    .data_out(d0), .sop_out(so0), .eop_out(eo0), .err_out(er0)
  );

  word_t       word_q[$];
  val_t        exp_q[$];
  logic [31:0] pw[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          stall_from = -100;
  int          stall_len = 0;
  int          last_fire, fire_count, gaps, err_count;
  bit          exp_err = 1'b0;
  bit          err_next;
  bit          ignore_out = 1'b0;
  bit          saw_ro_low;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic add_word(input logic [31:0] d, input bit s, input bit e, input bit m);
    word_q.push_back('{d: d, sop: s, eop: e, mid: m});
  endtask

  task automatic expect_val(input logic [6:0] d, input bit s, input bit e);
    exp_q.push_back('{d: d, sop: s, eop: e});
  endtask

  // Model: concatenate the packet LSB-first and slice it into 7-bit values.
  task automatic expect_packet(input bit pad);
    logic [255:0] bits;
    int n, nv, rem;
    bits = '0;
    n = 32 * pw.size();
    foreach (pw[i]) bits[i*32 +: 32] = pw[i];
    nv  = n / 7;
    rem = n % 7;
    for (int i = 0; i < nv; i++)
      expect_val(bits[i*7 +: 7], i == 0, (i == nv - 1) && !(pad && rem != 0));
    if (pad && rem != 0) expect_val(bits[nv*7 +: 7], nv == 0, 1'b1);
  endtask

  task automatic queue_packet(input bit pad);
    foreach (pw[i]) add_word(pw[i], i == 0, i == pw.size() - 1, 1'b0);
    expect_packet(pad);
    pw.delete();
  endtask

  task automatic reset_stats();
    last_fire  = -1;
    fire_count = 0;
    gaps       = 0;
    err_count  = 0;
    saw_ro_low = 1'b0;
  endtask

  task automatic applyStimulus();
    ready_in = !(cyc >= stall_from && cyc < stall_from + stall_len);
    if (word_q.size() != 0) begin
      valid_in = 1'b1;
      data_in  = word_q[0].d;
      sop_in   = word_q[0].sop;
      eop_in   = word_q[0].eop;
    end else begin
      valid_in = 1'b0;
      data_in  = '0;
      sop_in   = 1'b0;
      eop_in   = 1'b0;
    end
    @(negedge clk);
    if (!ready_in && valid_in && !ro) saw_ro_low = 1'b1;
    if (er === 1'b1) err_count++;
    checkOutput("err_out", er, exp_err);
    if (!ignore_out && vo) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected valid_out", vo, 0);
      end else begin
        checkOutput("data_out", dout, exp_q[0].d);
        checkOutput("sop_out", so, exp_q[0].sop);
        checkOutput("eop_out", eo, exp_q[0].eop);
        if (ready_in) begin
          if (last_fire >= 0 && cyc - last_fire != 1) gaps++;
          last_fire = cyc;
          fire_count++;
          void'(exp_q.pop_front());
        end
      end
    end
    err_next = valid_in && ro && word_q.size() != 0 && word_q[0].mid;
    if (valid_in && ro) void'(word_q.pop_front());
    @(posedge clk);
    #1;
    exp_err = err_next;
    cyc++;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((word_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
      applyStimulus();
      n++;
    end
    checkOutput("drained within budget", (word_q.size() == 0 && exp_q.size() == 0), 1);
  endtask

  task automatic load_seven(input logic [31:0] base);
    pw.push_back(32'hF00CC05A ^ base);
    pw.push_back(32'h12345678 ^ base);
    pw.push_back(32'h9ABCDEF0 ^ base);
    pw.push_back(32'hDEADBEEF ^ base);
    pw.push_back(32'h0F0F0F0F ^ base);
    pw.push_back(32'hA5A5A5A5 ^ base);
    pw.push_back(32'h13579BDF ^ base);
  endtask

  initial begin
    rst_n = 1'b0; valid_in = 1'b0; data_in = '0; sop_in = 1'b0; eop_in = 1'b0;
    ready_in = 1'b1; sel = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset valid_out", vo1, 0);
    checkOutput("reset ready_out", ro1, 0);
    checkOutput("reset sop/eop/err", {so1, eo1, er1}, 0);
    checkOutput("reset data_out", d1, 0);
    checkOutput("reset nopad valid_out", vo0, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // First word F00CC05A gives 5A,00,33,00; whole 7-word packet is 32 values back to back
    reset_stats();
    load_seven(32'h0);
    queue_packet(1'b1);
    drain(80);
    checkOutput("seven-word value count", fire_count, 32);
    checkOutput("seven-word gaps", gaps, 0);

    // Same packet with ready_in low for 3 cycles mid-packet
    reset_stats();
    stall_from = cyc + 6;
    stall_len  = 3;
    load_seven(32'h0);
    queue_packet(1'b1);
    drain(80);
    checkOutput("stall value count", fire_count, 32);
    checkOutput("ready_out dropped during stall", saw_ro_low, 1);
    stall_len = 0;

    // Back-to-back packets with no dead cycle between eop and next sop
    reset_stats();
    load_seven(32'h0);
    queue_packet(1'b1);
    load_seven(32'h5A5A_0FF0);
    queue_packet(1'b1);
    drain(160);
    checkOutput("back-to-back value count", fire_count, 64);
    checkOutput("back-to-back gaps", gaps, 0);

    // Word without sop outside a packet is swallowed
    reset_stats();
    add_word(32'h1234_5678, 1'b0, 1'b0, 1'b0);
    repeat (5) applyStimulus();
    checkOutput("discard word consumed", word_q.size(), 0);
    checkOutput("discard no output", fire_count, 0);

    // sop mid-packet: one err pulse, word still used as data
    reset_stats();
    add_word(32'hCAFEBABE, 1'b1, 1'b0, 1'b0);
    add_word(32'h01234567, 1'b1, 1'b0, 1'b1);
    add_word(32'h89ABCDEF, 1'b0, 1'b1, 1'b0);
    pw.push_back(32'hCAFEBABE);
    pw.push_back(32'h01234567);
    pw.push_back(32'h89ABCDEF);
    expect_packet(1'b1);
    pw.delete();
    drain(60);
    checkOutput("err pulse count", err_count, 1);

    // Padded residual: FFFFFFFF alone gives 7F x4 then 0F with eop
    reset_stats();
    add_word(32'hFFFFFFFF, 1'b1, 1'b1, 1'b0);
    expect_val(7'h7F, 1'b1, 1'b0);
    expect_val(7'h7F, 1'b0, 1'b0);
    expect_val(7'h7F, 1'b0, 1'b0);
    expect_val(7'h7F, 1'b0, 1'b0);
    expect_val(7'h0F, 1'b0, 1'b1);
    drain(30);
    checkOutput("padded value count", fire_count, 5);

    // Non-padded instance: residual dropped, next packet starts clean
    sel = 1'b1;
    reset_stats();
    add_word(32'hFFFFFFFF, 1'b1, 1'b1, 1'b0);
    add_word(32'h12345678, 1'b1, 1'b1, 1'b0);
    expect_val(7'h7F, 1'b1, 1'b0);
    expect_val(7'h7F, 1'b0, 1'b0);
    expect_val(7'h7F, 1'b0, 1'b0);
    expect_val(7'h7F, 1'b0, 1'b1);
    expect_val(7'h78, 1'b1, 1'b0);
    expect_val(7'h2C, 1'b0, 1'b0);
    expect_val(7'h51, 1'b0, 1'b0);
    expect_val(7'h11, 1'b0, 1'b1);
    drain(40);
    checkOutput("nopad value count", fire_count, 8);
    checkOutput("nopad gaps", gaps, 0);
    sel = 1'b0;

    // Reset mid-packet drops the residual; the following packet is clean
    reset_stats();
    ignore_out = 1'b1;
    add_word(32'hAAAA5555, 1'b1, 1'b0, 1'b0);
    add_word(32'h11111111, 1'b0, 1'b0, 1'b0);
    repeat (3) applyStimulus();
    valid_in = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("mid-packet reset valid_out", vo1, 0);
    checkOutput("mid-packet reset eop_out", eo1, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    word_q.delete();
    exp_q.delete();
    ignore_out = 1'b0;
    exp_err = 1'b0;
    pw.push_back(32'h0BADF00D);
    pw.push_back(32'h7654_3210);
    queue_packet(1'b1);
    drain(40);
    checkOutput("post-reset value count", fire_count, 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
